// File: rtl/sub_word_unit.sv
// sub_word_unit: iterative AES SubBytes / InvSubBytes over a LANES-byte word,
// PAR bytes per clock. Accepts a word in IDLE, substitutes it over
// N = LANES/PAR cycles in BUSY, then holds the result in DONE until taken.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   in_data/in_inv valid this cycle
//   in_ready   unit accepts a word this cycle (IDLE only)
//   in_data    word to substitute, byte k at [8k+7:8k]
//   in_inv     0 = forward S-box, 1 = inverse S-box (sampled at accept)
//   out_valid  out_data holds a completed result (DONE)
//   out_ready  downstream takes out_data this cycle
//   out_data   work register, same byte order as in_data
//   busy       high in BUSY and DONE
module sub_word_unit #(
  parameter int unsigned LANES = 4,
  parameter int unsigned PAR   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  if (LANES < 1 || LANES > 16 || PAR < 1 || (LANES % PAR) != 0) begin : g_bad_params
    $error("sub_word_unit: LANES must be 1..16 and a multiple of PAR");
  end

  localparam int unsigned N  = LANES / PAR;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:255][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table is derived from the forward one at elaboration so the two
  // can never disagree.
  function automatic logic [0:255][7:0] invert_table(input logic [0:255][7:0] f);
    logic [0:255][7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 256; i++) begin
      r[f[i]] = 8'(i);
    end
    return r;
  endfunction

  localparam logic [0:255][7:0] INV_SBOX = invert_table(FWD_SBOX);

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    return inv ? INV_SBOX[b] : FWD_SBOX[b];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [8*LANES-1:0]   work_q, work_d;
  logic                 inv_q, inv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          work_d  = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // One S-box lookup per parallel slot; slot p handles byte cnt*PAR+p.
        for (int unsigned p = 0; p < PAR; p++) begin
          work_d[(32'(cnt_q) * PAR + p) * 8 +: 8] =
            sub_byte(work_q[(32'(cnt_q) * PAR + p) * 8 +: 8], inv_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_sub_word_unit.sv
// Directed bench for sub_word_unit: reset state, forward/inverse vectors,
// latency for PAR=1/2/4, DONE back-pressure, reset mid-word, and a
// per-lane sweep of all 256 byte values in both directions.
module tb_sub_word_unit;

  localparam logic [0:255][7:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        inv;
  logic        v1, v2, v4;
  logic        r1, r2, r4;
  logic        ir1, ir2, ir4;
  logic        ov1, ov2, ov4;
  logic        b1, b2, b4;
  logic [31:0] od1, od2, od4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sub_word_unit #(.LANES(4), .PAR(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_data(din),
    .in_inv(inv), .out_valid(ov1), .out_ready(r1), .out_data(od1), .busy(b1));
  sub_word_unit #(.LANES(4), .PAR(2)) d2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(din),
    .in_inv(inv), .out_valid(ov2), .out_ready(r2), .out_data(od2), .busy(b2));
  sub_word_unit #(.LANES(4), .PAR(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_data(din),
    .in_inv(inv), .out_valid(ov4), .out_ready(r4), .out_data(od4), .busy(b4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_word(input logic [31:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = SB[d[8*k +: 8]];
    return r;
  endfunction

  // Waits for out_valid on d1 with a cycle bound; returns cycles waited.
  task automatic wait_d1(output int lat);
    lat = 0;
    while (!ov1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_word(input logic [31:0] d, input logic m, output logic [31:0] res);
    int lat;
    din = d; inv = m; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    wait_d1(lat);
    check("sweep_latency", 32'(lat), 32'd4);
    res = od1;
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
  endtask

  initial begin
    int          lat, lat2, lat4;
    logic [31:0] res, res2, word;

    rst = 1'b1; din = '0; inv = 1'b0;
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
    r1 = 1'b0; r2 = 1'b0; r4 = 1'b0;
    tick();
    tick();
    check("reset_in_ready", 32'(ir1), 32'd1);
    check("reset_out_valid", 32'(ov1), 32'd0);
    check("reset_busy", 32'(b1), 32'd0);
    check("reset_out_data", od1, 32'h0);

    // First edge with rst low accepts; in_inv change and in_valid during
    // BUSY, plus out_ready before DONE, must all be ignored.
    rst = 1'b0; din = 32'h00010253; inv = 1'b0; v1 = 1'b1;
    tick();
    check("accept_busy", 32'(b1), 32'd1);
    check("accept_in_ready", 32'(ir1), 32'd0);
    check("accept_work_reg", od1, 32'h00010253);
    din = 32'hffffffff; inv = 1'b1; r1 = 1'b1;
    wait_d1(lat);
    v1 = 1'b0; r1 = 1'b0;
    check("fwd_latency", 32'(lat), 32'd4);
    check("fwd_data", od1, 32'h637c77ed);
    check("done_in_ready", 32'(ir1), 32'd0);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    check("release_idle", 32'(ir1), 32'd1);
    check("release_out_valid", 32'(ov1), 32'd0);
    check("release_busy", 32'(b1), 32'd0);

    run_word(32'h637c77ed, 1'b1, res);
    check("inv_data", res, 32'h00010253);

    // DONE back-pressure with in_valid pulsing; no accept on the release edge.
    din = 32'hcafebabe; inv = 1'b0; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    wait_d1(lat);
    check("hold_latency", 32'(lat), 32'd4);
    din = 32'h12345678; v1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", od1, 32'h74bbf4ae);
      check("hold_in_ready", 32'(ir1), 32'd0);
      check("hold_out_valid", 32'(ov1), 32'd1);
    end
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    check("handoff_idle", 32'(ir1), 32'd1);
    check("handoff_no_accept", 32'(b1), 32'd0);
    v1 = 1'b0;

    // Reset two cycles into a word discards it.
    din = 32'h00010253; inv = 1'b1; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 32'(ov1), 32'd0);
    check("midrst_out_data", od1, 32'h0);
    check("midrst_in_ready", 32'(ir1), 32'd1);
    check("midrst_busy", 32'(b1), 32'd0);
    run_word(32'h53535353, 1'b0, res);
    check("after_rst_data", res, 32'hedededed);

    // PAR=2 and PAR=4 instances on the same vector.
    din = 32'h00010253; inv = 1'b0; v2 = 1'b1; v4 = 1'b1;
    tick();
    v2 = 1'b0; v4 = 1'b0;
    lat2 = 0; lat4 = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ov2 && lat2 == 0) lat2 = c;
      if (ov4 && lat4 == 0) lat4 = c;
    end
    check("par2_latency", 32'(lat2), 32'd2);
    check("par4_latency", 32'(lat4), 32'd1);
    check("par2_data", od2, 32'h637c77ed);
    check("par4_data", od4, 32'h637c77ed);
    r2 = 1'b1; r4 = 1'b1;
    tick();
    r2 = 1'b0; r4 = 1'b0;
    check("par2_idle", 32'(ir2), 32'd1);
    check("par4_idle", 32'(ir4), 32'd1);

    // Each lane sees every byte value once, forward then back.
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) word[8*k +: 8] = 8'(w + 64 * k);
      run_word(word, 1'b0, res);
      check("sweep_fwd", res, fwd_word(word));
      run_word(res, 1'b1, res2);
      check("sweep_inv", res2, word);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_word_unit.md
SUB_WORD_UNIT -- requirements
Module: sub_word_unit

Interface
REQ-001 Parameter LANES, default 4: number of bytes per word; legal range 1..16.
REQ-002 Parameter PAR, default 1: number of byte substitutions per clock; LANES % PAR != 0 SHALL be an elaboration error.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_data/in_inv are valid this cycle.
REQ-006 in_ready  output  1  unit can accept a word this cycle.
REQ-007 in_data  input  8*LANES  word to substitute; byte k at bits [8k+7:8k].
REQ-008 in_inv  input  1  0 = forward AES S-box, 1 = inverse AES S-box.
REQ-009 out_valid  output  1  out_data holds a completed result.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  8*LANES  substituted word, same byte order as in_data.
REQ-012 busy  output  1  high in states BUSY and DONE.

Function
REQ-013 States SHALL be IDLE, BUSY and DONE; N = LANES/PAR; the step counter width is max(1, clog2(N)).
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid=1 SHALL load in_data into the work register, latch in_inv, clear the counter and enter BUSY.
REQ-015 BUSY: each edge SHALL replace bytes [cnt*PAR .. cnt*PAR+PAR-1] of the work register with S(byte) or S^-1(byte), per the latched in_inv, then increment cnt.
REQ-016 BUSY: the edge that processes cnt = N-1 SHALL enter DONE; out_valid SHALL be high exactly N cycles after the acceptance edge.
REQ-017 DONE: out_valid=1 and in_ready=0; out_data and out_valid SHALL stay stable until out_ready=1, and the edge with out_ready=1 SHALL enter IDLE.
REQ-018 No new word SHALL be accepted in the DONE-to-IDLE transition cycle; the minimum issue interval is N+2 cycles with out_ready held high.
REQ-019 in_ready SHALL be low in BUSY and DONE; in_valid in those states SHALL be ignored, with no state change.
REQ-020 in_inv SHALL be sampled only at acceptance; changes during BUSY SHALL have no effect.
REQ-021 out_data SHALL always equal the work register; bytes not yet processed hold their input values, and only DONE contents are meaningful.
REQ-022 Forward table: the FIPS-197 AES S-box, e.g. 00->63, 01->7c, 53->ed, ff->16.
REQ-023 Inverse table: the exact inverse of the forward table, e.g. 63->00, 00->52, ed->53, 16->ff.
REQ-024 The block SHALL implement PAR lookup instances only, each combinational, with no extra latency.
REQ-025 out_ready while not in DONE SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force, at the next edge: state IDLE, cnt=0, work register 0, latched inv 0, out_valid=0, busy=0, in_ready=1.
REQ-027 rst asserted in BUSY or DONE SHALL discard the word in progress with no output handshake; rst has priority over every other input.
REQ-028 The first accept SHALL be possible on the first edge where rst=0.

Verification
REQ-029 LANES=4, PAR=1, in_data=0x00010253, in_inv=0 -> out_valid 4 cycles after accept, out_data=0x637c77ed.
REQ-030 Same configuration, in_data=0x637c77ed, in_inv=1 -> out_data=0x00010253.
REQ-031 LANES=4, PAR=2 and LANES=4, PAR=4 with the vector of REQ-029 -> identical result, latency 2 and 1 cycles.
REQ-032 Hold out_ready=0 for 5 cycles in DONE, pulse in_valid meanwhile -> out_data stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle.
REQ-033 rst=1 two cycles after accept -> next cycle out_valid=0, out_data=0, in_ready=1; a following word completes correctly.
REQ-034 Exhaustive sweep: all 256 byte values per lane, both modes -> forward matches the table, and inverse(forward(x)) = x.
